// File: rtl/circle_pkg.sv
// Shared types and constants for the circle rasteriser.
// The S_CLEAR state exists only when CIRCLE_ENGINE_CLEAR_EN is defined.
package circle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OCT,
        S_STEP,
        S_DONE
`ifdef CIRCLE_ENGINE_CLEAR_EN
        , S_CLEAR
`endif
    } state_t;

    typedef logic [2:0] oct_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    // Signed coordinate width: widest operand plus room for the sign and a carry.
    function automatic int coord_width(input int x_dw, input int y_dw, input int r_dw);
        int m;
        m = x_dw;
        if (y_dw > m) m = y_dw;
        if (r_dw > m) m = r_dw;
        return m + 2;
    endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Combinational octant reflection of the current (ox, oy) offset around the
// centre, followed by screen clipping and the per-octant enable mask.
module circle_octant_map
    import circle_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int X_DW      = 8,
    parameter int Y_DW      = 7,
    parameter int RADIUS_DW = 8
) (
    input  logic [X_DW-1:0]      cx,
    input  logic [Y_DW-1:0]      cy,
    input  logic [RADIUS_DW-1:0] ox,
    input  logic [RADIUS_DW-1:0] oy,
    input  oct_t                 oct,
    input  logic [7:0]           mask,
    input  logic                 active,
    output logic [X_DW-1:0]      px,
    output logic [Y_DW-1:0]      py,
    output logic                 plot
);
    localparam int CW = coord_width(X_DW, Y_DW, RADIUS_DW);
    typedef logic signed [CW-1:0] coord_t;

    coord_t sx, sy, sox, soy, px_s, py_s;
    logic   in_x, in_y;

    assign sx  = coord_t'({{(CW-X_DW){1'b0}}, cx});
    assign sy  = coord_t'({{(CW-Y_DW){1'b0}}, cy});
    assign sox = coord_t'({{(CW-RADIUS_DW){1'b0}}, ox});
    assign soy = coord_t'({{(CW-RADIUS_DW){1'b0}}, oy});

    always_comb begin
        px_s = sx + sox;
        py_s = sy + soy;
        case (oct)
            3'd0: begin px_s = sx + sox; py_s = sy + soy; end
            3'd1: begin px_s = sx + soy; py_s = sy + sox; end
            3'd2: begin px_s = sx - soy; py_s = sy + sox; end
            3'd3: begin px_s = sx - sox; py_s = sy + soy; end
            3'd4: begin px_s = sx - sox; py_s = sy - soy; end
            3'd5: begin px_s = sx - soy; py_s = sy - sox; end
            3'd6: begin px_s = sx + soy; py_s = sy - sox; end
            3'd7: begin px_s = sx + sox; py_s = sy - soy; end
        endcase
    end

    // Coordinates are forced to zero whenever no pixel is written.
    always_comb begin
        in_x = !px_s[CW-1] && (px_s < coord_t'(SCREEN_W));
        in_y = !py_s[CW-1] && (py_s < coord_t'(SCREEN_H));
        plot = active && mask[oct] && in_x && in_y;
        px   = plot ? px_s[X_DW-1:0] : '0;
        py   = plot ? py_s[Y_DW-1:0] : '0;
    end

endmodule

// File: rtl/circle_engine.sv
// Self-sequenced Bresenham circle rasteriser driving the VGA pixel interface.
// Define CIRCLE_ENGINE_CLEAR_EN to add a full-screen clear sweep before drawing.
module circle_engine
    import circle_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int X_DW      = 8,
    parameter int Y_DW      = 7,
    parameter int RADIUS_DW = 8,
    parameter int COLOUR_DW = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
`ifdef CIRCLE_ENGINE_CLEAR_EN
    input  logic                 clear_first,
`endif
    input  logic [X_DW-1:0]      centre_x,
    input  logic [Y_DW-1:0]      centre_y,
    input  logic [RADIUS_DW-1:0] radius,
    input  logic [COLOUR_DW-1:0] colour,
    input  logic [7:0]           oct_mask,
    output logic                 busy,
    output logic                 done,
    output logic [X_DW-1:0]      vga_x,
    output logic [Y_DW-1:0]      vga_y,
    output logic [COLOUR_DW-1:0] vga_colour,
    output logic                 vga_plot
);
    localparam int OW  = RADIUS_DW + 2;
    localparam int CRW = RADIUS_DW + 3;

    state_t                state, state_n;
    oct_t                  oct, oct_n;
    logic [X_DW-1:0]       cx_q, cx_n;
    logic [Y_DW-1:0]       cy_q, cy_n;
    logic [COLOUR_DW-1:0]  colour_q, colour_n;
    logic [7:0]            mask_q, mask_n;
    logic signed [OW-1:0]  ox, ox_n, oy, oy_n;
    logic signed [CRW-1:0] crit, crit_n;
    int                    ox_i, oy_i, crit_i;

    logic [X_DW-1:0]       map_x;
    logic [Y_DW-1:0]       map_y;
    logic                  map_plot;

`ifdef CIRCLE_ENGINE_CLEAR_EN
    logic [X_DW-1:0]       clr_x, clr_x_n;
    logic [Y_DW-1:0]       clr_y, clr_y_n;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            oct      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            colour_q <= '0;
            mask_q   <= '0;
            ox       <= '0;
            oy       <= '0;
            crit     <= '0;
`ifdef CIRCLE_ENGINE_CLEAR_EN
            clr_x    <= '0;
            clr_y    <= '0;
`endif
        end else begin
            state    <= state_n;
            oct      <= oct_n;
            cx_q     <= cx_n;
            cy_q     <= cy_n;
            colour_q <= colour_n;
            mask_q   <= mask_n;
            ox       <= ox_n;
            oy       <= oy_n;
            crit     <= crit_n;
`ifdef CIRCLE_ENGINE_CLEAR_EN
            clr_x    <= clr_x_n;
            clr_y    <= clr_y_n;
`endif
        end
    end

    // The step arithmetic runs in int so ox may go negative (radius 0) without wrapping.
    always_comb begin
        state_n  = state;
        oct_n    = oct;
        cx_n     = cx_q;
        cy_n     = cy_q;
        colour_n = colour_q;
        mask_n   = mask_q;
        ox_n     = ox;
        oy_n     = oy;
        crit_n   = crit;
        ox_i     = 0;
        oy_i     = 0;
        crit_i   = 0;
`ifdef CIRCLE_ENGINE_CLEAR_EN
        clr_x_n  = clr_x;
        clr_y_n  = clr_y;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    cx_n     = centre_x;
                    cy_n     = centre_y;
                    colour_n = colour;
                    mask_n   = oct_mask;
                    ox_n     = OW'(radius);
                    oy_n     = '0;
                    crit_n   = CRW'(1 - int'(radius));
                    oct_n    = '0;
                    state_n  = S_OCT;
`ifdef CIRCLE_ENGINE_CLEAR_EN
                    clr_x_n  = '0;
                    clr_y_n  = '0;
                    if (clear_first) state_n = S_CLEAR;
`endif
                end
            end
            S_OCT: begin
                oct_n = oct + 3'd1;
                if (oct == 3'd7) state_n = S_STEP;
            end
            S_STEP: begin
                oy_i = int'(oy) + 1;
                if (crit[CRW-1] || (crit == '0)) begin
                    ox_i   = int'(ox);
                    crit_i = int'(crit) + 2 * oy_i + 1;
                end else begin
                    ox_i   = int'(ox) - 1;
                    crit_i = int'(crit) + 2 * (oy_i - ox_i) + 1;
                end
                oy_n    = OW'(oy_i);
                ox_n    = OW'(ox_i);
                crit_n  = CRW'(crit_i);
                oct_n   = '0;
                state_n = (oy_i <= ox_i) ? S_OCT : S_DONE;
            end
            S_DONE: state_n = S_IDLE;
`ifdef CIRCLE_ENGINE_CLEAR_EN
            S_CLEAR: begin
                if (clr_y == Y_DW'(SCREEN_H - 1)) begin
                    clr_y_n = '0;
                    if (clr_x == X_DW'(SCREEN_W - 1)) state_n = S_OCT;
                    else clr_x_n = clr_x + 1'b1;
                end else begin
                    clr_y_n = clr_y + 1'b1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    circle_octant_map #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .X_DW      (X_DW),
        .Y_DW      (Y_DW),
        .RADIUS_DW (RADIUS_DW)
    ) u_map (
        .cx     (cx_q),
        .cy     (cy_q),
        .ox     (ox[RADIUS_DW-1:0]),
        .oy     (oy[RADIUS_DW-1:0]),
        .oct    (oct),
        .mask   (mask_q),
        .active (state == S_OCT),
        .px     (map_x),
        .py     (map_y),
        .plot   (map_plot)
    );

    always_comb begin
        busy       = (state == S_OCT) || (state == S_STEP);
        done       = (state == S_DONE);
        vga_x      = map_x;
        vga_y      = map_y;
        vga_plot   = map_plot;
        vga_colour = (state == S_OCT) ? colour_q : '0;
`ifdef CIRCLE_ENGINE_CLEAR_EN
        if (state == S_CLEAR) begin
            busy       = 1'b1;
            vga_x      = clr_x;
            vga_y      = clr_y;
            vga_plot   = 1'b1;
            vga_colour = '0;
        end
`endif
    end

endmodule
